apb_arbiter_2m: RTL and testbench
=================================

Name: apb_arbiter_2m

Overview:
Shares the single 8-bit/5-bit APB register-file port between two APB masters. Master 0 is the I2C-to-APB bridge; master 1 is a second host bridge or on-chip sequencer. The block arbitrates round-robin and regenerates a legal APB setup/access sequence toward the slave. It stalls the losing master through its PREADY and terminates hung slave accesses with a timeout error.

Parameters:
ADDR_W, 5, APB address width
DATA_W, 8, APB data width
TIMEOUT, 16, max ACCESS cycles waiting for s_pready before forced error completion; 0 disables the timeout

Ports:
CLK  in  1  clock
RESETn  in  1  reset, asynchronous, active-low
m0_psel  in  1  master 0 select (request)
m0_penable  in  1  master 0 enable (ignored for arbitration; protocol only)
m0_paddr  in  ADDR_W  master 0 address
m0_pwrite  in  1  master 0 write
m0_pwdata  in  DATA_W  master 0 write data
m0_prdata  out  DATA_W  read data to master 0
m0_pready  out  1  transfer complete to master 0
m0_pslverr  out  1  error (timeout) to master 0
m1_psel, m1_penable, m1_paddr, m1_pwrite, m1_pwdata, m1_prdata, m1_pready, m1_pslverr: same as m0_*, for master 1
s_psel  out  1  slave select
s_penable  out  1  slave enable
s_paddr  out  ADDR_W  slave address
s_pwrite  out  1  slave write
s_pwdata  out  DATA_W  slave write data
s_prdata  in  DATA_W  slave read data
s_pready  in  1  slave ready
grant  out  1  index of currently/last granted master
busy  out  1  high in SETUP or ACCESS

Behaviour:
- Reset (async, RESETn=0): state IDLE, priority pointer=0, grant=0, timeout counter=0. All outputs 0.
- States: IDLE, SETUP, ACCESS (registered).
- IDLE: request = mX_psel.
  - Only one master requesting: grant it.
  - Both requesting: the master named by the priority pointer wins.
  - On any grant: register grant, go to SETUP. No request: stay in IDLE.
- SETUP: s_psel=1, s_penable=0 for one cycle; then ACCESS.
- ACCESS: s_psel=1, s_penable=1.
  - If s_pready=1: granted master sees pready=1 and prdata=s_prdata in the same cycle. Pointer is set to the other master; go to IDLE.
  - Else if TIMEOUT≠0 and counter==TIMEOUT-1: granted master sees pready=1, pslverr=1, prdata=0 this cycle. Pointer is set to the other master; go to IDLE.
  - Otherwise increment the counter and stay in ACCESS.
  - Counter clears on entry to SETUP.
- s_paddr/s_pwrite/s_pwdata: combinational mux of the granted master's inputs during SETUP/ACCESS; 0 in IDLE.
- Non-granted master, and any master in IDLE: pready=0, pslverr=0, prdata=0.
- Latency: with a zero-wait slave, master PREADY arrives 2 cycles after the arbiter first samples its psel (IDLE→SETUP→ACCESS). There is one mandatory IDLE cycle between consecutive slave transfers.
- Abort: if the granted master drops psel in SETUP or ACCESS, the block returns to IDLE next cycle with no pready/pslverr. The pointer is unchanged, and the slave sees psel drop.
- A simultaneous s_pready=1 and timeout expiry in the same cycle counts as normal completion (pslverr=0).
- Reset mid-transfer: all outputs go to 0 immediately, with no completion returned.
- busy = state≠IDLE. grant holds its last value in IDLE.

Test Plan:
- Single write: m0 psel=1, paddr=5'h03, pwrite=1, pwdata=8'hA5, slave pready=1 → s_psel at cycle+1, s_penable at cycle+2 with s_paddr=03/s_pwdata=A5; m0_pready=1 at cycle+2; m1 outputs stay 0.
- Contention: m0 and m1 request reads in the same cycle after reset (pointer=0); slave returns 8'h11 then 8'h22 → m0 completes first with prdata=11; m1 completes 3 cycles later with prdata=22, and grant goes 0→1.
- Round-robin fairness: m0 and m1 hold requests continuously for 6 transfers → grants alternate 0,1,0,1,0,1; no master waits more than one transfer.
- Wait states: slave holds pready=0 for 3 ACCESS cycles, then 1 → master pready asserts exactly on the 4th ACCESS cycle, and s_paddr/s_pwdata stay stable throughout.
- Timeout: TIMEOUT=16, slave never asserts pready → after 16 ACCESS cycles m1_pready=1, m1_pslverr=1, m1_prdata=0; next cycle s_psel=0 and busy=0.
- Async reset: assert RESETn=0 mid-ACCESS between clock edges → s_psel, s_penable, busy and mX_pready go to 0 before the next edge; the first transfer after release grants m0.

Source files
------------

// File: rtl/apb_arbiter_2m.sv
// Two-master round-robin APB arbiter in front of a single register-file slave.
// Regenerates SETUP/ACCESS toward the slave, stalls the loser, and times out hung accesses.
module apb_arbiter_2m #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              m0_psel,
  input  logic              m0_penable,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic              m0_pwrite,
  input  logic [DATA_W-1:0] m0_pwdata,
  output logic [DATA_W-1:0] m0_prdata,
  output logic              m0_pready,
  output logic              m0_pslverr,
  input  logic              m1_psel,
  input  logic              m1_penable,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic              m1_pwrite,
  input  logic [DATA_W-1:0] m1_pwdata,
  output logic [DATA_W-1:0] m1_prdata,
  output logic              m1_pready,
  output logic              m1_pslverr,
  output logic              s_psel,
  output logic              s_penable,
  output logic [ADDR_W-1:0] s_paddr,
  output logic              s_pwrite,
  output logic [DATA_W-1:0] s_pwdata,
  input  logic [DATA_W-1:0] s_prdata,
  input  logic              s_pready,
  output logic              grant,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state;
  logic             ptr;
  logic             gnt;
  logic [CNT_W-1:0] cnt;

  logic req_any, pick, gnt_psel, in_access, to_hit;
  logic done_ok, done_err, done;

  // master penable plays no part in arbitration
  logic penable_unused;
  assign penable_unused = m0_penable ^ m1_penable;

  always_comb begin
    req_any   = m0_psel | m1_psel;
    pick      = (m0_psel && m1_psel) ? ptr : m1_psel;
    gnt_psel  = gnt ? m1_psel : m0_psel;
    in_access = (state == ACCESS) && gnt_psel;
    to_hit    = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    // slave ready wins over a coincident timeout
    done_ok   = in_access && s_pready;
    done_err  = in_access && !s_pready && to_hit;
    done      = done_ok || done_err;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
      ptr   <= 1'b0;
      gnt   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            gnt   <= pick;
            cnt   <= '0;
            state <= SETUP;
          end
        end
        SETUP: state <= gnt_psel ? ACCESS : IDLE;
        ACCESS: begin
          if (!gnt_psel) begin
            state <= IDLE;
          end else if (done) begin
            ptr   <= ~gnt;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_psel    = (state != IDLE);
  assign s_penable = (state == ACCESS);
  assign s_paddr   = s_psel ? (gnt ? m1_paddr  : m0_paddr)  : '0;
  assign s_pwrite  = s_psel ? (gnt ? m1_pwrite : m0_pwrite) : 1'b0;
  assign s_pwdata  = s_psel ? (gnt ? m1_pwdata : m0_pwdata) : '0;

  assign m0_pready  = done && !gnt;
  assign m0_pslverr = done_err && !gnt;
  assign m0_prdata  = (done_ok && !gnt) ? s_prdata : '0;
  assign m1_pready  = done && gnt;
  assign m1_pslverr = done_err && gnt;
  assign m1_prdata  = (done_ok && gnt) ? s_prdata : '0;

  assign grant = gnt;
  assign busy  = s_psel;

endmodule

// File: tb/tb_apb_arbiter_2m.sv
// Directed bench for apb_arbiter_2m: stimulus pushes expected completions, a monitor pops and compares.
module tb_apb_arbiter_2m;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic       m0_psel, m0_penable, m0_pwrite, m0_pready, m0_pslverr;
  logic [4:0] m0_paddr;
  logic [7:0] m0_pwdata, m0_prdata;
  logic       m1_psel, m1_penable, m1_pwrite, m1_pready, m1_pslverr;
  logic [4:0] m1_paddr;
  logic [7:0] m1_pwdata, m1_prdata;
  logic       s_psel, s_penable, s_pwrite, s_pready;
  logic [4:0] s_paddr;
  logic [7:0] s_pwdata, s_prdata;
  logic       grant, busy;

  apb_arbiter_2m #(.ADDR_W(5), .DATA_W(8), .TIMEOUT(16)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_paddr(m0_paddr), .m0_pwrite(m0_pwrite),
    .m0_pwdata(m0_pwdata), .m0_prdata(m0_prdata), .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_paddr(m1_paddr), .m1_pwrite(m1_pwrite),
    .m1_pwdata(m1_pwdata), .m1_prdata(m1_prdata), .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
    .s_psel(s_psel), .s_penable(s_penable), .s_paddr(s_paddr), .s_pwrite(s_pwrite),
    .s_pwdata(s_pwdata), .s_prdata(s_prdata), .s_pready(s_pready),
    .grant(grant), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       m;
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // slave model: register memory with configurable wait states or hang
  logic [7:0] mem [32];
  int         slv_wait = 0;
  logic       slv_hang = 1'b0;
  int         acc = 0;

  assign s_prdata = mem[s_paddr];

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[1] = 8'h11;
    mem[2] = 8'h22;
    s_pready = 1'b0;
    forever begin
      @(posedge CLK);
      if (s_psel && s_penable && s_pready && s_pwrite) mem[s_paddr] = s_pwdata;
      #1;
      if (s_psel && s_penable) acc = acc + 1;
      else acc = 0;
      s_pready = !slv_hang && (acc > slv_wait);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    logic am;
    forever begin
      @(negedge CLK);
      if (m0_pready === 1'b1 || m1_pready === 1'b1) begin
        chk("sb_exclusive", {31'd0, m0_pready & m1_pready}, 32'd0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got completion m0=%0b m1=%0b expected none", m0_pready, m1_pready);
        end else begin
          e  = q.pop_front();
          am = m1_pready;
          chk("sb_master", {31'd0, am}, {31'd0, e.m});
          chk("sb_prdata", {24'd0, am ? m1_prdata : m0_prdata}, {24'd0, e.d});
          chk("sb_pslverr", {31'd0, am ? m1_pslverr : m0_pslverr}, {31'd0, e.e});
        end
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg;
    @(negedge CLK);
  endtask

  task automatic m_req(input int m, input logic [4:0] a, input logic w, input logic [7:0] d);
    if (m == 0) begin
      m0_psel = 1'b1; m0_paddr = a; m0_pwrite = w; m0_pwdata = d;
    end else begin
      m1_psel = 1'b1; m1_paddr = a; m1_pwrite = w; m1_pwdata = d;
    end
  endtask

  task automatic m_drop(input int m);
    if (m == 0) m0_psel = 1'b0;
    else m1_psel = 1'b0;
  endtask

  task automatic push(input logic m, input logic [7:0] d, input logic e);
    exp_t x;
    x.m = m; x.d = d; x.e = e;
    q.push_back(x);
  endtask

  task automatic do_reset;
    RESETn = 1'b0;
    m0_psel = 1'b0;
    m1_psel = 1'b0;
    repeat (2) tick();
    RESETn = 1'b1;
  endtask

  // both masters read at once with pointer 0: m0 then m1, three cycles apart
  task automatic contention;
    m_req(0, 5'h01, 1'b0, 8'h00);
    m_req(1, 5'h02, 1'b0, 8'h00);
    push(1'b0, 8'h11, 1'b0);
    push(1'b1, 8'h22, 1'b0);
    tick(); at_neg();
    chk("cont_grant0", {31'd0, grant}, 32'd0);
    tick(); at_neg();
    chk("cont_m0_ready", {31'd0, m0_pready}, 32'd1);
    tick(); m_drop(0);
    tick(); at_neg();
    chk("cont_grant1", {31'd0, grant}, 32'd1);
    chk("cont_setup_pen", {31'd0, s_penable}, 32'd0);
    tick(); at_neg();
    chk("cont_m1_ready", {31'd0, m1_pready}, 32'd1);
    tick(); m_drop(1);
  endtask

  initial begin
    m0_penable = 1'b0; m1_penable = 1'b0;
    m0_paddr = '0; m0_pwrite = 1'b0; m0_pwdata = '0;
    m1_paddr = '0; m1_pwrite = 1'b0; m1_pwdata = '0;
    RESETn = 1'b0;
    m0_psel = 1'b0; m1_psel = 1'b0;
    at_neg();
    chk("rst_s_psel", {31'd0, s_psel}, 32'd0);
    chk("rst_s_penable", {31'd0, s_penable}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {31'd0, grant}, 32'd0);
    chk("rst_m0_pready", {31'd0, m0_pready}, 32'd0);
    chk("rst_m1_pready", {31'd0, m1_pready}, 32'd0);
    do_reset();

    // single write from m0
    m_req(0, 5'h03, 1'b1, 8'hA5);
    push(1'b0, 8'h00, 1'b0);
    at_neg();
    chk("wr_idle_busy", {31'd0, busy}, 32'd0);
    tick(); at_neg();
    chk("wr_setup_psel", {31'd0, s_psel}, 32'd1);
    chk("wr_setup_pen", {31'd0, s_penable}, 32'd0);
    tick(); at_neg();
    chk("wr_acc_pen", {31'd0, s_penable}, 32'd1);
    chk("wr_paddr", {27'd0, s_paddr}, 32'h03);
    chk("wr_pwdata", {24'd0, s_pwdata}, 32'hA5);
    chk("wr_pwrite", {31'd0, s_pwrite}, 32'd1);
    chk("wr_m0_ready", {31'd0, m0_pready}, 32'd1);
    chk("wr_m1_quiet", {23'd0, m1_pready, m1_pslverr, m1_prdata}, 32'd0);
    tick(); m_drop(0); at_neg();
    chk("wr_after_busy", {31'd0, busy}, 32'd0);
    chk("wr_after_paddr", {27'd0, s_paddr}, 32'd0);

    // m1 reads the written location back
    m_req(1, 5'h03, 1'b0, 8'h00);
    push(1'b1, 8'hA5, 1'b0);
    repeat (3) tick();
    m_drop(1);

    do_reset();
    contention();

    // round-robin: both hold requests for six transfers
    do_reset();
    m_req(0, 5'h01, 1'b0, 8'h00);
    m_req(1, 5'h02, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 8'h11, 1'b0);
      push(1'b1, 8'h22, 1'b0);
    end
    repeat (18) tick();
    m_drop(0); m_drop(1);

    // abort in ACCESS leaves the pointer at m0
    slv_hang = 1'b1;
    m_req(1, 5'h02, 1'b0, 8'h00);
    tick(); tick();
    m_drop(1);
    at_neg();
    chk("abort_m1_ready", {31'd0, m1_pready}, 32'd0);
    tick(); at_neg();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_s_psel", {31'd0, s_psel}, 32'd0);
    slv_hang = 1'b0;
    contention();

    // three wait states
    slv_wait = 3;
    m_req(0, 5'h04, 1'b1, 8'h3C);
    push(1'b0, 8'h00, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      tick(); at_neg();
      chk("ws_pen", {31'd0, s_penable}, 32'd1);
      chk("ws_paddr", {27'd0, s_paddr}, 32'h04);
      chk("ws_pwdata", {24'd0, s_pwdata}, 32'h3C);
      chk("ws_not_ready", {31'd0, m0_pready}, 32'd0);
    end
    tick(); at_neg();
    chk("ws_ready4", {31'd0, m0_pready}, 32'd1);
    chk("ws_paddr4", {27'd0, s_paddr}, 32'h04);
    tick(); m_drop(0);
    slv_wait = 0;

    // async reset in ACCESS, pointer was 1
    m_req(0, 5'h01, 1'b0, 8'h00);
    m_req(1, 5'h04, 1'b0, 8'h00);
    tick(); at_neg();
    chk("ar_pre_grant", {31'd0, grant}, 32'd1);
    tick();
    #1 RESETn = 1'b0;
    #1;
    chk("ar_s_psel", {31'd0, s_psel}, 32'd0);
    chk("ar_s_penable", {31'd0, s_penable}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_m1_ready", {31'd0, m1_pready}, 32'd0);
    chk("ar_m0_ready", {31'd0, m0_pready}, 32'd0);
    #1 RESETn = 1'b1;
    push(1'b0, 8'h11, 1'b0);
    push(1'b1, 8'h3C, 1'b0);
    tick(); at_neg();
    chk("ar_post_grant", {31'd0, grant}, 32'd0);
    repeat (5) tick();
    m_drop(0); m_drop(1);

    // timeout on a hung slave
    slv_hang = 1'b1;
    m_req(1, 5'h02, 1'b0, 8'h00);
    push(1'b1, 8'h00, 1'b1);
    tick();
    repeat (15) tick();
    at_neg();
    chk("to_not_yet", {31'd0, m1_pready}, 32'd0);
    tick(); at_neg();
    chk("to_ready", {31'd0, m1_pready}, 32'd1);
    chk("to_slverr", {31'd0, m1_pslverr}, 32'd1);
    chk("to_prdata", {24'd0, m1_prdata}, 32'd0);
    tick(); m_drop(1); at_neg();
    chk("to_s_psel", {31'd0, s_psel}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd0);
    slv_hang = 1'b0;

    // ready on the timeout cycle completes normally
    slv_wait = 15;
    m_req(0, 5'h01, 1'b0, 8'h00);
    push(1'b0, 8'h11, 1'b0);
    tick();
    repeat (15) tick();
    at_neg();
    chk("tie_not_yet", {31'd0, m0_pready}, 32'd0);
    tick(); at_neg();
    chk("tie_ready", {31'd0, m0_pready}, 32'd1);
    chk("tie_slverr", {31'd0, m0_pslverr}, 32'd0);
    tick(); m_drop(0);
    slv_wait = 0;

    repeat (2) tick();
    chk("sb_drain", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
